// File: rtl/rv32i_fetch_queue_pkg.sv
// rv32i_fetch_queue_pkg: shared RV32I word, fetch packet and predecoded instruction types.
package rv32i_fetch_queue_pkg;
    typedef logic [31:0] rv32i_word;
    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_packet_t;
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        rv32i_word i_imm;
        rv32i_word s_imm;
        rv32i_word b_imm;
        rv32i_word u_imm;
        rv32i_word j_imm;
    } instruction_decoded;
endpackage

// File: rtl/rv32i_fetch_queue_predecode.sv
// rv32i_predecode: combinational RV32I field extraction and sign-extended immediates.
module rv32i_predecode
    import rv32i_fetch_queue_pkg::*;
(
    input  rv32i_word          instr,
    output instruction_decoded dec
);
    always_comb begin
        dec.opcode = instr[6:0];
        dec.rd     = instr[11:7];
        dec.funct3 = instr[14:12];
        dec.rs1    = instr[19:15];
        dec.rs2    = instr[24:20];
        dec.funct7 = instr[31:25];
        dec.i_imm  = {{20{instr[31]}}, instr[31:20]};
        dec.s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec.b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec.u_imm  = {instr[31:12], 12'b0};
        dec.j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end
endmodule

// File: rtl/rv32i_fetch_queue.sv
// rv32i_fetch_queue: fetch-to-decode packet queue with flush, optional empty bypass
// and a predecoded view of the head instruction.
module rv32i_fetch_queue
    import rv32i_fetch_queue_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1,
    parameter bit BYPASS    = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output instruction_decoded         out_dec,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);

    fetch_packet_t mem [DEPTH];
    fetch_packet_t head;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic empty, full, bypass, push, pop, store, deq;

    // bypass is masked by rst so an in-flight packet never shows while resetting
    always_comb begin
        empty       = count == '0;
        full        = count == FULL_LVL;
        bypass      = BYPASS && empty && in_valid && !rst;
        in_ready    = !full && !flush;
        out_valid   = !flush && (!empty || bypass);
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
        store       = push && !(bypass && pop);
        deq         = pop && !empty;
        head        = bypass ? {in_pc, in_instr} : mem[rd_ptr];
        out_pc      = head.pc;
        out_instr   = head.instr;
        almost_full = count >= AF_LVL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) begin
                mem[wr_ptr] <= {in_pc, in_instr};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(store) - CW'(deq);
        end
    end

    rv32i_predecode u_predecode (
        .instr (out_instr),
        .dec   (out_dec)
    );
endmodule

// File: tb/tb_rv32i_fetch_queue.sv
// tb_rv32i_fetch_queue: directed scoreboard bench for the queue in non-bypass and bypass builds.
module tb_rv32i_fetch_queue;
    import rv32i_fetch_queue_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, fl0, iv0, ir0, ov0, or0, af0;
    logic [31:0] pc0, in0, opc0, oin0;
    logic [2:0] cnt0;
    instruction_decoded dec0;
    logic rst1, fl1, iv1, ir1, ov1, or1, af1;
    logic [31:0] pc1, in1, opc1, oin1;
    logic [2:0] cnt1;
    instruction_decoded dec1;

    rv32i_fetch_queue #(.DEPTH(4), .AF_MARGIN(1), .BYPASS(1'b0)) u0 (
        .clk(clk), .rst(rst0), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
        .in_pc(pc0), .in_instr(in0), .out_valid(ov0), .out_ready(or0),
        .out_pc(opc0), .out_instr(oin0), .out_dec(dec0), .count(cnt0), .almost_full(af0)
    );
    rv32i_fetch_queue #(.DEPTH(4), .AF_MARGIN(1), .BYPASS(1'b1)) u1 (
        .clk(clk), .rst(rst1), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
        .in_pc(pc1), .in_instr(in1), .out_valid(ov1), .out_ready(or1),
        .out_pc(opc1), .out_instr(oin1), .out_dec(dec1), .count(cnt1), .almost_full(af1)
    );

    int vec = 0;
    int err = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_cmp(input string name, input logic [63:0] act, input int sz, input logic [63:0] exp);
        vec++;
        if (sz == 0) begin
            err++;
            $display("FAIL %s: got pc/instr %h with nothing expected", name, act);
        end else if (act !== exp) begin
            err++;
            $display("FAIL %s: got pc/instr %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // scoreboard fill: record each accepted packet; flush/reset discard what is queued
    always @(negedge clk) begin
        if (fl0) q0.delete();
        else if (!rst0 && iv0 && ir0) q0.push_back({pc0, in0});
        if (!rst1 && iv1 && ir1) q1.push_back({pc1, in1});
    end
    always @(posedge rst1) q1.delete();

    always begin
        @(negedge clk);
        #2;
        if (!rst0 && ov0 && or0) begin
            logic [63:0] e0;
            int s0;
            s0 = q0.size();
            e0 = (s0 > 0) ? q0.pop_front() : 64'h0;
            sb_cmp("sb0_head", {opc0, oin0}, s0, e0);
        end
        if (!rst1 && ov1 && or1) begin
            logic [63:0] e1;
            int s1;
            s1 = q1.size();
            e1 = (s1 > 0) ? q1.pop_front() : 64'h0;
            sb_cmp("sb1_head", {opc1, oin1}, s1, e1);
        end
    end

    task automatic dec_push(input logic [31:0] ins);
        pc0 = 32'h70; in0 = ins; iv0 = 1'b1;
        tick;
        iv0 = 1'b0;
        #1;
    endtask

    task automatic dec_pop;
        or0 = 1'b1;
        tick;
        or0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst0 = 1; fl0 = 0; iv0 = 0; or0 = 0; pc0 = 0; in0 = 0;
        rst1 = 1; fl1 = 0; iv1 = 0; or1 = 0; pc1 = 0; in1 = 0;
        tick; tick;
        chk("rst_in_ready", 32'(ir0), 1);
        chk("rst_out_valid", 32'(ov0), 0);
        chk("rst_count", 32'(cnt0), 0);
        chk("rst_almost_full", 32'(af0), 0);
        chk("rst_out_pc", opc0, 0);
        rst0 = 0; rst1 = 0;
        tick;

        // addi x1,x0,5
        pc0 = 32'h60; in0 = 32'h00500093; iv0 = 1;
        tick;
        iv0 = 0;
        #1;
        chk("first_out_valid", 32'(ov0), 1);
        chk("first_out_pc", opc0, 32'h60);
        chk("first_rd", 32'(dec0.rd), 1);
        chk("first_i_imm", dec0.i_imm, 5);
        chk("first_count", 32'(cnt0), 1);
        dec_pop;
        chk("first_drained", 32'(cnt0), 0);

        dec_push(32'hFE20AE23);
        chk("sw_s_imm", dec0.s_imm, 32'hFFFFFFFC);
        chk("sw_rs1", 32'(dec0.rs1), 1);
        chk("sw_rs2", 32'(dec0.rs2), 2);
        dec_pop;
        dec_push(32'h123452B7);
        chk("lui_u_imm", dec0.u_imm, 32'h12345000);
        chk("lui_rd", 32'(dec0.rd), 5);
        dec_pop;
        dec_push(32'hFF9FF06F);
        chk("jal_j_imm", dec0.j_imm, 32'hFFFFFFF8);
        chk("jal_opcode", 32'(dec0.opcode), 32'h6F);
        dec_pop;
        dec_push(32'hFE208EE3);
        chk("beq_b_imm", dec0.b_imm, 32'hFFFFFFFC);
        chk("beq_funct3", 32'(dec0.funct3), 0);
        dec_pop;

        // fill to full with decode stalled
        iv0 = 1;
        for (int i = 0; i < 4; i++) begin
            pc0 = 32'(i * 4); in0 = 32'h13 + 32'(i << 8);
            tick;
            chk("fill_count", 32'(cnt0), 32'(i + 1));
            chk("fill_almost_full", 32'(af0), (i + 1 >= 3) ? 1 : 0);
        end
        chk("full_in_ready", 32'(ir0), 0);
        pc0 = 32'h10; in0 = 32'h413;
        tick;
        chk("full_hold_count", 32'(cnt0), 4);
        or0 = 1;
        #1;
        chk("full_pop_in_ready", 32'(ir0), 0);
        tick;
        chk("full_pop_count", 32'(cnt0), 3);
        or0 = 0;
        tick;
        chk("refill_count", 32'(cnt0), 4);
        iv0 = 0; or0 = 1;
        tick; tick;
        or0 = 0;
        chk("drain2_count", 32'(cnt0), 2);

        // steady push+pop across pointer wrap
        iv0 = 1; or0 = 1;
        for (int i = 0; i < 20; i++) begin
            pc0 = 32'h100 + 32'(i * 4); in0 = 32'h93 + 32'(i << 12);
            tick;
            chk("steady_count", 32'(cnt0), 2);
        end
        or0 = 0;
        pc0 = 32'h180; in0 = 32'h113;
        tick;
        iv0 = 0;
        chk("preflush_count", 32'(cnt0), 3);

        fl0 = 1; iv0 = 1; or0 = 1; pc0 = 32'h1C0;
        #1;
        chk("flush_in_ready", 32'(ir0), 0);
        chk("flush_out_valid", 32'(ov0), 0);
        tick;
        fl0 = 0; iv0 = 0; or0 = 0;
        #1;
        chk("postflush_count", 32'(cnt0), 0);
        chk("postflush_out_valid", 32'(ov0), 0);
        pc0 = 32'h200; in0 = 32'h00A00193; iv0 = 1;
        tick;
        iv0 = 0;
        #1;
        chk("afterflush_out_valid", 32'(ov0), 1);
        chk("afterflush_out_pc", opc0, 32'h200);
        dec_pop;
        chk("afterflush_count", 32'(cnt0), 0);
        chk("sb0_drained", 32'(q0.size()), 0);

        // bypass build: pass-through, then async reset mid-burst
        pc1 = 32'h80; in1 = 32'h00000013; iv1 = 1; or1 = 1;
        #1;
        chk("bypass_out_valid", 32'(ov1), 1);
        chk("bypass_out_pc", opc1, 32'h80);
        chk("bypass_count_now", 32'(cnt1), 0);
        tick;
        chk("bypass_count_after", 32'(cnt1), 0);
        or1 = 0;
        pc1 = 32'h84; in1 = 32'h00100113;
        tick;
        pc1 = 32'h88; in1 = 32'h00200193;
        tick;
        chk("burst_count", 32'(cnt1), 2);
        pc1 = 32'h8C;
        #2;
        rst1 = 1;
        #1;
        chk("async_rst_out_valid", 32'(ov1), 0);
        chk("async_rst_count", 32'(cnt1), 0);
        iv1 = 0;
        tick;
        rst1 = 0;
        tick;
        pc1 = 32'h90; in1 = 32'h00300213; iv1 = 1; or1 = 1;
        #1;
        chk("rebypass_out_valid", 32'(ov1), 1);
        chk("rebypass_out_pc", opc1, 32'h90);
        tick;
        iv1 = 0; or1 = 0;
        chk("rebypass_count", 32'(cnt1), 0);
        chk("sb1_drained", 32'(q1.size()), 0);

        tick;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
